apb_vgachargen_if: RTL and testbench

- APB3 slave that bridges CPU accesses into the write/read ("a") ports of the text-mode memories: character map, colour map and writable character table.
- Sits directly upstream of the text-mode video top. It drives the ch_map, col_map and ch_t_rw port-A signals; the video pipeline owns port B.
- Sequences byte-wide map accesses and 128-bit glyph read-modify-write over several cycles, stretching APB with PREADY.

---
 rtl/apb_vgachargen_if.sv | 214 +++++++++++++++++++++
 tb/tb_apb_vgachargen_if.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_vgachargen_if.sv
// APB3 slave feeding port A of the text-mode char map, colour map and writable char table.
// Byte-wide map accesses and 128-bit glyph read-modify-write are sequenced over several cycles while PREADY is held low.
module apb_vgachargen_if #(
    parameter int MAP_ENTRIES  = 2400,
    parameter int CH_T_ENTRIES = 128,
    parameter int APB_ADDR_W   = 14
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [APB_ADDR_W-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [11:0]           ch_map_addr_o,
    output logic [7:0]            ch_map_data_o,
    output logic                  ch_map_wen_o,
    input  logic [7:0]            ch_map_data_i,
    output logic [11:0]           col_map_addr_o,
    output logic [7:0]            col_map_data_o,
    output logic                  col_map_wen_o,
    input  logic [7:0]            col_map_data_i,
    output logic [6:0]            ch_t_rw_addr_o,
    output logic [127:0]          ch_t_rw_data_o,
    output logic                  ch_t_rw_wen_o,
    input  logic [127:0]          ch_t_rw_data_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MAP_WR = 3'd1;
    localparam logic [2:0] S_MAP_RD = 3'd2;
    localparam logic [2:0] S_CT_RD  = 3'd3;
    localparam logic [2:0] S_CT_MOD = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [9:0]   waddr_q, waddr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   strb_q, strb_d;
    logic         write_q, write_d;
    logic         err_q, err_d;
    logic         col_q, col_d;
    logic [31:0]  rdata_q, rdata_d;

    logic [11:0]  map_addr;
    logic [7:0]   map_data;
    logic         map_wen;
    logic [6:0]   ct_addr;
    logic [127:0] ct_wdata;
    logic         ct_wen;
    logic [127:0] merged;

    logic         map_off_ok, ch_hit, col_hit, ct_hit;
    logic [11:0]  map_base;
    logic [7:0]   lane_byte;
    logic [7:0]   map_rd_byte;
    logic [1:0]   rd_lane;
    logic [1:0]   ct_lane;
    logic [6:0]   ct_entry;
    logic         unused_lsbs;

    assign unused_lsbs = ^paddr_i[1:0];

    assign map_off_ok  = paddr_i[11:0] < 12'(MAP_ENTRIES);
    assign ch_hit      = (paddr_i[13:12] == 2'b00) && map_off_ok;
    assign col_hit     = (paddr_i[13:12] == 2'b01) && map_off_ok;
    assign ct_hit      = (paddr_i[13:11] == 3'b100) && (int'(paddr_i[10:4]) < CH_T_ENTRIES);

    assign map_base    = {waddr_q, 2'b00};
    assign lane_byte   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    assign map_rd_byte = col_q ? col_map_data_i : ch_map_data_i;
    // Read data lags the issued address by one cycle, so count k fills lane k-1.
    assign rd_lane     = cnt_q[1:0] - 2'd1;
    assign ct_lane     = waddr_q[1:0];
    assign ct_entry    = waddr_q[8:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        write_d  = write_q;
        err_d    = err_q;
        col_d    = col_q;
        rdata_d  = rdata_q;
        map_addr = '0;
        map_data = '0;
        map_wen  = 1'b0;
        ct_addr  = '0;
        ct_wdata = '0;
        ct_wen   = 1'b0;
        merged   = ch_t_rw_data_i;
        for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
                merged[int'(ct_lane) * 32 + b * 8 +: 8] = wdata_q[b * 8 +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (psel_i && penable_i) begin
                    waddr_d = paddr_i[11:2];
                    wdata_d = pwdata_i;
                    strb_d  = pstrb_i;
                    write_d = pwrite_i;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    col_d   = 1'b0;
                    if (ch_hit) begin
                        state_d = pwrite_i ? S_MAP_WR : S_MAP_RD;
                    end else if (col_hit) begin
                        col_d   = 1'b1;
                        state_d = pwrite_i ? S_MAP_WR : S_MAP_RD;
                    end else if (ct_hit) begin
                        state_d = S_CT_RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_MAP_WR: begin
                // Counts 0..3 write one lane each; count 4 is a quiet turnaround cycle.
                if (cnt_q < 3'd4) begin
                    map_addr = map_base | {10'd0, cnt_q[1:0]};
                    map_data = lane_byte;
                    map_wen  = strb_q[cnt_q[1:0]];
                    cnt_d    = cnt_q + 3'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_MAP_RD: begin
                if (cnt_q < 3'd4) begin
                    map_addr = map_base | {10'd0, cnt_q[1:0]};
                end
                if (cnt_q >= 3'd1 && cnt_q <= 3'd4) begin
                    rdata_d[{rd_lane, 3'b000} +: 8] = map_rd_byte;
                end
                if (cnt_q == 3'd5) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_CT_RD: begin
                ct_addr = ct_entry;
                state_d = S_CT_MOD;
            end
            S_CT_MOD: begin
                ct_addr = ct_entry;
                if (write_q) begin
                    ct_wdata = merged;
                    ct_wen   = 1'b1;
                end else begin
                    rdata_d = ch_t_rw_data_i[int'(ct_lane) * 32 +: 32];
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            err_q   <= err_d;
            col_q   <= col_d;
            rdata_q <= rdata_d;
        end
    end

    assign pready_o       = (state_q == S_RESP);
    assign pslverr_o      = pready_o && err_q;
    assign prdata_o       = (pready_o && !write_q && !err_q) ? rdata_q : 32'd0;

    assign ch_map_addr_o  = col_q ? 12'd0 : map_addr;
    assign ch_map_data_o  = col_q ? 8'd0  : map_data;
    assign ch_map_wen_o   = map_wen && !col_q;
    assign col_map_addr_o = col_q ? map_addr : 12'd0;
    assign col_map_data_o = col_q ? map_data : 8'd0;
    assign col_map_wen_o  = map_wen && col_q;
    assign ch_t_rw_addr_o = ct_addr;
    assign ch_t_rw_data_o = ct_wdata;
    assign ch_t_rw_wen_o  = ct_wen;

endmodule

// File: tb/tb_apb_vgachargen_if.sv
// Bench for apb_vgachargen_if: behavioural memories on port A, a word-level reference model,
// directed scenarios from the feature list plus a randomized transfer stream.
module tb_apb_vgachargen_if;

    logic         clk;
    logic         arst_i;
    logic         psel_i, penable_i, pwrite_i;
    logic [13:0]  paddr_i;
    logic [31:0]  pwdata_i;
    logic [3:0]   pstrb_i;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o;
    logic [11:0]  ch_map_addr_o, col_map_addr_o;
    logic [7:0]   ch_map_data_o, col_map_data_o;
    logic         ch_map_wen_o, col_map_wen_o;
    logic [7:0]   ch_map_data_i, col_map_data_i;
    logic [6:0]   ch_t_rw_addr_o;
    logic [127:0] ch_t_rw_data_o, ch_t_rw_data_i;
    logic         ch_t_rw_wen_o;

    int checks = 0;
    int errors = 0;

    apb_vgachargen_if #(.MAP_ENTRIES(2400), .CH_T_ENTRIES(128), .APB_ADDR_W(14)) dut (
        .clk_i(clk), .arst_i(arst_i),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
        .ch_map_wen_o(ch_map_wen_o), .ch_map_data_i(ch_map_data_i),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
        .col_map_wen_o(col_map_wen_o), .col_map_data_i(col_map_data_i),
        .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o),
        .ch_t_rw_wen_o(ch_t_rw_wen_o), .ch_t_rw_data_i(ch_t_rw_data_i)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    function automatic logic [7:0] init_ch(int i);
        return 8'((i * 7 + 3) & 255);
    endfunction
    function automatic logic [7:0] init_col(int i);
        return 8'((i * 13 + 90) & 255);
    endfunction
    function automatic logic [127:0] init_ct(int i);
        if (i == 1) return '1;
        return {4{32'(i) * 32'h9E3779B1}};
    endfunction

    logic [7:0]   ch_mem  [0:2399];
    logic [7:0]   col_mem [0:2399];
    logic [127:0] ct_mem  [0:127];
    logic [19:0]  ch_ev_q[$];
    logic [19:0]  col_ev_q[$];
    int           n_ch = 0, n_col = 0, n_ct = 0;
    logic [6:0]   last_ct_addr = '0;
    logic [127:0] last_ct_data = '0;
    bit           mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2400; i++) begin
                ch_mem[i]  <= init_ch(i);
                col_mem[i] <= init_col(i);
            end
            for (int i = 0; i < 128; i++) ct_mem[i] <= init_ct(i);
            mem_init_done <= 1'b1;
        end else begin
            ch_map_data_i  <= ch_mem[ch_map_addr_o];
            col_map_data_i <= col_mem[col_map_addr_o];
            ch_t_rw_data_i <= ct_mem[ch_t_rw_addr_o];
            if (ch_map_wen_o) begin
                ch_mem[ch_map_addr_o] <= ch_map_data_o;
                ch_ev_q.push_back({ch_map_addr_o, ch_map_data_o});
                n_ch <= n_ch + 1;
            end
            if (col_map_wen_o) begin
                col_mem[col_map_addr_o] <= col_map_data_o;
                col_ev_q.push_back({col_map_addr_o, col_map_data_o});
                n_col <= n_col + 1;
            end
            if (ch_t_rw_wen_o) begin
                ct_mem[ch_t_rw_addr_o] <= ch_t_rw_data_o;
                last_ct_addr <= ch_t_rw_addr_o;
                last_ct_data <= ch_t_rw_data_o;
                n_ct <= n_ct + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]   ref_ch  [0:2399];
    logic [7:0]   ref_col [0:2399];
    logic [127:0] ref_ct  [0:127];

    task automatic model_xfer(input logic w, input logic [13:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] erd, output logic eerr,
                              output int ecyc, output int ench, output int encol, output int enct);
        int base, ent, lane;
        erd = '0; eerr = 1'b0; ench = 0; encol = 0; enct = 0; ecyc = 0;
        if (a < 14'h0960 || (a >= 14'h1000 && a < 14'h1960)) begin
            base = int'(a) & 'hFFC;
            for (int k = 0; k < 4; k++) begin
                if (a < 14'h1000) begin
                    if (w && s[k]) ref_ch[base + k] = d[8 * k +: 8];
                    if (!w) erd[8 * k +: 8] = ref_ch[base + k];
                end else begin
                    if (w && s[k]) ref_col[base + k] = d[8 * k +: 8];
                    if (!w) erd[8 * k +: 8] = ref_col[base + k];
                end
            end
            ecyc = w ? 6 : 7;
            if (w && a < 14'h1000) ench = $countones(s);
            if (w && a >= 14'h1000) encol = $countones(s);
        end else if (a >= 14'h2000 && a < 14'h2800) begin
            ent  = (int'(a) - 'h2000) / 16;
            lane = (int'(a) / 4) % 4;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_ct[ent][lane * 32 + b * 8 +: 8] = d[b * 8 +: 8];
                enct = 1;
            end else begin
                erd = ref_ct[ent][lane * 32 +: 32];
            end
            ecyc = 3;
        end else begin
            eerr = 1'b1;
            ecyc = 1;
        end
    endtask

    // ---------------- drivers ----------------
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          cy, exp_cy, e_ch, e_col, e_ct;

    task automatic apb_xfer(input logic w, input logic [13:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] ord, output logic oer,
                            output int ocy);
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = w; paddr_i = a; pwdata_i = d; pstrb_i = s;
        @(posedge clk); #1;
        penable_i = 1'b1;
        ocy = 0;
        while (pready_o !== 1'b1 && ocy < 40) begin
            @(posedge clk); #1;
            ocy++;
        end
        ord = prdata_o;
        oer = pslverr_o;
        if (pready_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%h got pready=%b required 1", a, pready_o);
        end
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        arst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pready_o, pslverr_o, prdata_o, ch_map_addr_o, ch_map_data_o, ch_map_wen_o,
             col_map_addr_o, col_map_data_o, col_map_wen_o, ch_t_rw_addr_o, ch_t_rw_data_o,
             ch_t_rw_wen_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pready=%b slverr=%b prdata=%h chwen=%b colwen=%b ctwen=%b required all 0",
                     pready_o, pslverr_o, prdata_o, ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o);
        end
        @(posedge clk); #1;
        arst_i = 1'b0;
    endtask

    task automatic test_map_basic();
        int b0, c0;
        logic [19:0] ev;
        b0 = ch_ev_q.size(); c0 = n_col;
        model_xfer(1'b1, 14'h0000, 32'h44434241, 4'hF, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, 14'h0000, 32'h44434241, 4'hF, rd, er, cy);
        apb_idle();
        checks++;
        if (cy !== 6 || er !== 1'b0) begin
            errors++; $display("FAIL basic_wr_resp got cycle=%0d slverr=%b required 6/0", cy, er);
        end
        checks++;
        if (ch_ev_q.size() - b0 !== 4 || n_col !== c0) begin
            errors++; $display("FAIL basic_wr_count got ch=%0d col=%0d required 4/0", ch_ev_q.size() - b0, n_col - c0);
        end
        for (int k = 0; k < 4; k++) begin
            ev = (ch_ev_q.size() > b0 + k) ? ch_ev_q[b0 + k] : 20'hxxxxx;
            checks++;
            if (ev !== {12'(k), 8'(8'h41 + k)}) begin
                errors++; $display("FAIL basic_wr_lane%0d got %h required %h", k, ev, {12'(k), 8'(8'h41 + k)});
            end
        end
        model_xfer(1'b0, 14'h0000, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b0, 14'h0000, 32'h0, 4'h0, rd, er, cy);
        apb_idle();
        checks++;
        if (rd !== 32'h44434241 || cy !== 7 || er !== 1'b0) begin
            errors++; $display("FAIL basic_rd got prdata=%h cycle=%0d slverr=%b required 44434241/7/0", rd, cy, er);
        end
    endtask

    task automatic test_col_strobe();
        int b0, h0;
        logic [19:0] ev0, ev1;
        b0 = col_ev_q.size(); h0 = n_ch;
        model_xfer(1'b1, 14'h1010, 32'hAABBCCDD, 4'h5, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, 14'h1010, 32'hAABBCCDD, 4'h5, rd, er, cy);
        apb_idle();
        ev0 = (col_ev_q.size() > b0) ? col_ev_q[b0] : 20'hxxxxx;
        ev1 = (col_ev_q.size() > b0 + 1) ? col_ev_q[b0 + 1] : 20'hxxxxx;
        checks++;
        if (col_ev_q.size() - b0 !== 2 || n_ch !== h0 || cy !== 6) begin
            errors++; $display("FAIL col_strobe_count got col=%0d ch=%0d cycle=%0d required 2/0/6", col_ev_q.size() - b0, n_ch - h0, cy);
        end
        checks++;
        if (ev0 !== {12'd16, 8'hDD} || ev1 !== {12'd18, 8'hBB}) begin
            errors++; $display("FAIL col_strobe_data got %h %h required %h %h", ev0, ev1, {12'd16, 8'hDD}, {12'd18, 8'hBB});
        end
    endtask

    task automatic test_errors();
        int tot0;
        tot0 = n_ch + n_col + n_ct;
        apb_xfer(1'b1, 14'h0960, 32'hDEADBEEF, 4'hF, rd, er, cy);
        apb_idle();
        checks++;
        if (er !== 1'b1 || cy !== 1 || rd !== 32'd0) begin
            errors++; $display("FAIL err_wr_0960 got slverr=%b cycle=%0d prdata=%h required 1/1/0", er, cy, rd);
        end
        apb_xfer(1'b0, 14'h3000, 32'h0, 4'h0, rd, er, cy);
        apb_idle();
        checks++;
        if (er !== 1'b1 || cy !== 1 || rd !== 32'd0) begin
            errors++; $display("FAIL err_rd_3000 got slverr=%b cycle=%0d prdata=%h required 1/1/0", er, cy, rd);
        end
        checks++;
        if (n_ch + n_col + n_ct !== tot0) begin
            errors++; $display("FAIL err_no_wen got %0d pulses required 0", n_ch + n_col + n_ct - tot0);
        end
    endtask

    task automatic test_char_table();
        int t0;
        t0 = n_ct;
        model_xfer(1'b1, 14'h2014, 32'h12345678, 4'h3, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, 14'h2014, 32'h12345678, 4'h3, rd, er, cy);
        apb_idle();
        checks++;
        if (n_ct - t0 !== 1 || last_ct_addr !== 7'd1 || cy !== 3 || er !== 1'b0) begin
            errors++; $display("FAIL ct_wr_pulse got pulses=%0d addr=%0d cycle=%0d required 1/1/3", n_ct - t0, last_ct_addr, cy);
        end
        checks++;
        if (last_ct_data !== 128'hFFFFFFFF_FFFFFFFF_FFFF5678_FFFFFFFF) begin
            errors++; $display("FAIL ct_wr_data got %h required ffffffffffffffffffff5678ffffffff", last_ct_data);
        end
        model_xfer(1'b0, 14'h2014, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b0, 14'h2014, 32'h0, 4'h0, rd, er, cy);
        apb_idle();
        checks++;
        if (rd !== 32'hFFFF5678 || cy !== 3) begin
            errors++; $display("FAIL ct_rd_lane1 got prdata=%h cycle=%0d required ffff5678/3", rd, cy);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        int b0;
        logic [19:0] ev;
        d = $urandom;
        b0 = col_ev_q.size();
        model_xfer(1'b1, 14'h195C, d, 4'hF, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, 14'h195C, d, 4'hF, rd, er, cy);
        apb_idle();
        checks++;
        if (er !== 1'b0 || col_ev_q.size() - b0 !== 4) begin
            errors++; $display("FAIL last_word_wr got slverr=%b pulses=%0d required 0/4", er, col_ev_q.size() - b0);
        end
        for (int k = 0; k < 4; k++) begin
            ev = (col_ev_q.size() > b0 + k) ? col_ev_q[b0 + k] : 20'hxxxxx;
            checks++;
            if (ev !== {12'(2396 + k), d[8 * k +: 8]}) begin
                errors++; $display("FAIL last_word_lane%0d got %h required %h", k, ev, {12'(2396 + k), d[8 * k +: 8]});
            end
        end
        model_xfer(1'b0, 14'h195C, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b0, 14'h195C, 32'h0, 4'h0, rd, er, cy);
        apb_idle();
        checks++;
        if (rd !== d || er !== 1'b0 || cy !== 7) begin
            errors++; $display("FAIL last_word_rd got prdata=%h slverr=%b required %h/0", rd, er, d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        int h0;
        d = $urandom;
        h0 = n_ch;
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 14'h0040; pwdata_i = d; pstrb_i = 4'hF;
        @(posedge clk); #1;
        penable_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ch_map_addr_o !== 12'd65 || ch_map_wen_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_lane1 got addr=%0d wen=%b required 65/1", ch_map_addr_o, ch_map_wen_o);
        end
        arst_i = 1'b1;
        #1;
        checks++;
        if ({pready_o, pslverr_o, prdata_o, ch_map_addr_o, ch_map_data_o, ch_map_wen_o,
             col_map_wen_o, ch_t_rw_wen_o, ch_t_rw_addr_o} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got pready=%b addr=%0d wen=%b required all 0", pready_o, ch_map_addr_o, ch_map_wen_o);
        end
        psel_i = 1'b0; penable_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        ref_ch[64] = d[7:0];
        checks++;
        if (n_ch - h0 !== 1) begin
            errors++; $display("FAIL rst_mid_pulses got %0d required 1", n_ch - h0);
        end
        d = $urandom;
        h0 = n_ch;
        model_xfer(1'b1, 14'h0040, d, 4'hF, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, 14'h0040, d, 4'hF, rd, er, cy);
        apb_idle();
        checks++;
        if (cy !== 6 || er !== 1'b0 || n_ch - h0 !== 4) begin
            errors++; $display("FAIL rst_after_wr got cycle=%0d slverr=%b pulses=%0d required 6/0/4", cy, er, n_ch - h0);
        end
    endtask

    task automatic test_protocol_drop();
        logic [13:0] a;
        int extra;
        a = 14'(4 * $urandom_range(0, 599));
        model_xfer(1'b0, a, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a; pwdata_i = '0; pstrb_i = '0;
        @(posedge clk); #1;
        penable_i = 1'b1;
        cy = 0;
        repeat (2) begin
            @(posedge clk); #1;
            cy++;
        end
        psel_i = 1'b0; penable_i = 1'b0;
        while (pready_o !== 1'b1 && cy < 40) begin
            @(posedge clk); #1;
            cy++;
        end
        rd = prdata_o;
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (pready_o === 1'b1) extra++;
        end
        checks++;
        if (rd !== exp_rd || cy !== 7 || extra !== 0) begin
            errors++; $display("FAIL drop_mid got prdata=%h cycle=%0d extra_resp=%0d required %h/7/0", rd, cy, extra, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] a;
        logic [31:0] d;
        a = 14'h1000 + 14'(4 * $urandom_range(0, 599));
        d = $urandom;
        model_xfer(1'b1, a, d, 4'hF, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, a, d, 4'hF, rd, er, cy);
        model_xfer(1'b0, a, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b0, a, 32'h0, 4'h0, rd, er, cy);
        checks++;
        if (rd !== d || cy !== 7) begin
            errors++; $display("FAIL b2b_map got prdata=%h cycle=%0d required %h/7", rd, cy, d);
        end
        a = 14'h2000 + 14'(4 * $urandom_range(0, 511));
        d = $urandom;
        model_xfer(1'b1, a, d, 4'h9, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b1, a, d, 4'h9, rd, er, cy);
        model_xfer(1'b0, a, 32'h0, 4'h0, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
        apb_xfer(1'b0, a, 32'h0, 4'h0, rd, er, cy);
        apb_idle();
        checks++;
        if (rd !== exp_rd || cy !== 3) begin
            errors++; $display("FAIL b2b_ct got prdata=%h cycle=%0d required %h/3", rd, cy, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [13:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        int r, h0, c0, t0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      a = 14'(4 * $urandom_range(0, 599));
            else if (r <= 6) a = 14'h1000 + 14'(4 * $urandom_range(0, 599));
            else if (r <= 8) a = 14'h2000 + 14'(4 * $urandom_range(0, 511));
            else begin
                case ($urandom_range(0, 3))
                    0:       a = 14'h0960 + 14'(4 * $urandom_range(0, 'h1A7));
                    1:       a = 14'h1960 + 14'(4 * $urandom_range(0, 'h1A7));
                    2:       a = 14'h2800 + 14'(4 * $urandom_range(0, 'h1FF));
                    default: a = 14'h3000 + 14'(4 * $urandom_range(0, 'h3FF));
                endcase
            end
            a = a | 14'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            h0 = n_ch; c0 = n_col; t0 = n_ct;
            model_xfer(w, a, d, s, exp_rd, exp_er, exp_cy, e_ch, e_col, e_ct);
            apb_xfer(w, a, d, s, rd, er, cy);
            if ($urandom_range(0, 1) == 1) apb_idle();
            checks++;
            if (rd !== exp_rd || er !== exp_er || cy !== exp_cy) begin
                errors++; $display("FAIL rand%0d_resp w=%b addr=%h got prdata=%h slverr=%b cycle=%0d required %h/%b/%0d",
                                   i, w, a, rd, er, cy, exp_rd, exp_er, exp_cy);
            end
            checks++;
            if (n_ch - h0 !== e_ch || n_col - c0 !== e_col || n_ct - t0 !== e_ct) begin
                errors++; $display("FAIL rand%0d_wen addr=%h got %0d/%0d/%0d required %0d/%0d/%0d",
                                   i, a, n_ch - h0, n_col - c0, n_ct - t0, e_ch, e_col, e_ct);
            end
        end
        apb_idle();
    endtask

    task automatic test_final_mem();
        int bad_ch, bad_col, bad_ct;
        bad_ch = 0; bad_col = 0; bad_ct = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2400; i++) begin
            if (ch_mem[i] !== ref_ch[i]) bad_ch++;
            if (col_mem[i] !== ref_col[i]) bad_col++;
        end
        for (int i = 0; i < 128; i++) if (ct_mem[i] !== ref_ct[i]) bad_ct++;
        checks++;
        if (bad_ch !== 0) begin errors++; $display("FAIL mem_ch got %0d bad entries required 0", bad_ch); end
        checks++;
        if (bad_col !== 0) begin errors++; $display("FAIL mem_col got %0d bad entries required 0", bad_col); end
        checks++;
        if (bad_ct !== 0) begin errors++; $display("FAIL mem_ct got %0d bad entries required 0", bad_ct); end
    endtask

    initial begin
        for (int i = 0; i < 2400; i++) begin
            ref_ch[i]  = init_ch(i);
            ref_col[i] = init_col(i);
        end
        for (int i = 0; i < 128; i++) ref_ct[i] = init_ct(i);
        test_reset();
        test_map_basic();
        test_col_strobe();
        test_errors();
        test_char_table();
        test_boundary();
        test_reset_mid_write();
        test_protocol_drop();
        test_back_to_back();
        test_random();
        test_final_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
